// File: rtl/cv32e40x_xif_aes_queue_pkg.sv
// Shared AES32 XIF definitions: opcode/funct5 constants, operation and entry-state enums, GF(2^8) helpers.
package cv32e40x_pkg;

    localparam logic [6:0] AES32     = 7'b0110011;
    localparam logic [4:0] AES32ESI  = 5'b10001;
    localparam logic [4:0] AES32ESMI = 5'b10011;
    localparam logic [4:0] AES32DSI  = 5'b10101;
    localparam logic [4:0] AES32DSMI = 5'b10111;

    typedef enum logic [1:0] {
        AES_ESI  = 2'd0,
        AES_ESMI = 2'd1,
        AES_DSI  = 2'd2,
        AES_DSMI = 2'd3
    } aes_op_e;

    typedef enum logic [1:0] {
        Q_FREE      = 2'd0,
        Q_ISSUED    = 2'd1,
        Q_COMMITTED = 2'd2,
        Q_KILLED    = 2'd3
    } aes_q_state_e;

    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = gf_xtime(x);
        end
        return p;
    endfunction

endpackage

// File: rtl/cv32e40x_xif_aes_queue_dp.sv
// Combinational AES32 datapath: byte select, S-box, optional MixColumn column, rotate, xor into rs1.
// The inverse S-box and inverse MixColumn exist only when CV32E40X_XIF_AES_DEC_EN is defined.
module cv32e40x_aes32_dp
    import cv32e40x_pkg::*;
(
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_rs2,
    input  logic [1:0]  i_bs,
    input  aes_op_e     i_op,
    output logic [31:0] o_rd
);

    // Multiplicative inverse as a^254 (square-and-multiply), which also maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        r = a;
        for (int i = 0; i < 6; i++) begin
            r = gf_mul(gf_mul(r, r), a);
        end
        return gf_mul(r, r);
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
        logic [7:0] v;
        v = gf_inv(a);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

`ifdef CV32E40X_XIF_AES_DEC_EN
    function automatic logic [7:0] sbox_inv(input logic [7:0] s);
        return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
    endfunction

    logic [7:0] w_si;
`endif

    logic [7:0]  w_x;
    logic [7:0]  w_sf;
    logic [31:0] w_t;
    logic [31:0] w_rot;

    always_comb begin
        case (i_bs)
            2'd0:    w_x = i_rs2[7:0];
            2'd1:    w_x = i_rs2[15:8];
            2'd2:    w_x = i_rs2[23:16];
            default: w_x = i_rs2[31:24];
        endcase
    end

    assign w_sf = sbox_fwd(w_x);
`ifdef CV32E40X_XIF_AES_DEC_EN
    assign w_si = sbox_inv(w_x);
`endif

    always_comb begin
        w_t = 32'h0;
        case (i_op)
            AES_ESI:  w_t = {24'h0, w_sf};
            AES_ESMI: w_t = {gf_mul(8'h03, w_sf), w_sf, w_sf, gf_xtime(w_sf)};
`ifdef CV32E40X_XIF_AES_DEC_EN
            AES_DSI:  w_t = {24'h0, w_si};
            AES_DSMI: w_t = {gf_mul(8'h0B, w_si), gf_mul(8'h0D, w_si),
                             gf_mul(8'h09, w_si), gf_mul(8'h0E, w_si)};
`endif
            default:  w_t = 32'h0;
        endcase
    end

    always_comb begin
        case (i_bs)
            2'd0:    w_rot = w_t;
            2'd1:    w_rot = {w_t[23:0], w_t[31:24]};
            2'd2:    w_rot = {w_t[15:0], w_t[31:16]};
            default: w_rot = {w_t[7:0], w_t[31:8]};
        endcase
    end

    assign o_rd = i_rs1 ^ w_rot;

endmodule

// File: rtl/cv32e40x_xif_aes_queue.sv
// Multi-outstanding AES32 XIF coprocessor: in-order entry buffer with commit/kill tracking and a registered result.
// aes32dsi/aes32dsmi are decoded as AES only when CV32E40X_XIF_AES_DEC_EN is defined.
module cv32e40x_xif_aes_queue
    import cv32e40x_pkg::*;
#(
    parameter int X_ID_WIDTH  = 4,
    parameter int X_RFR_WIDTH = 32,
    parameter int DEPTH       = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        issue_valid,
    output logic                        issue_ready,
    input  logic [31:0]                 issue_instr,
    input  logic [X_ID_WIDTH-1:0]       issue_id,
    input  logic [1:0][X_RFR_WIDTH-1:0] issue_rs,
    input  logic [1:0]                  issue_rs_valid,
    output logic                        issue_accept,
    output logic                        issue_writeback,
    input  logic                        commit_valid,
    input  logic [X_ID_WIDTH-1:0]       commit_id,
    input  logic                        commit_kill,
    output logic                        result_valid,
    input  logic                        result_ready,
    output logic [X_ID_WIDTH-1:0]       result_id,
    output logic [31:0]                 result_data,
    output logic [4:0]                  result_rd,
    output logic                        result_we
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]           r_head;
    logic [PW:0]           r_tail;
    aes_q_state_e          r_state [DEPTH];
    logic [X_ID_WIDTH-1:0] r_id    [DEPTH];
    aes_op_e               r_op    [DEPTH];
    logic [1:0]            r_bs    [DEPTH];
    logic [4:0]            r_rd    [DEPTH];
    logic [31:0]           r_rs1   [DEPTH];
    logic [31:0]           r_rs2   [DEPTH];

    logic                  r_res_valid;
    logic [X_ID_WIDTH-1:0] r_res_id;
    logic [31:0]           r_res_data;
    logic [4:0]            r_res_rd;

    logic                  w_f5_ok;
    logic                  w_is_aes;
    aes_op_e               w_op;
    logic                  w_full;
    logic [PW-1:0]         w_tidx;
    logic [PW-1:0]         w_hidx;
    logic                  w_res_free;
    logic                  w_pop_kill;
    logic                  w_pop_exec;
    logic [31:0]           w_dp_rd;
    logic                  w_unused_instr;

    always_comb begin
        w_f5_ok = 1'b0;
        w_op    = AES_ESI;
        case (issue_instr[29:25])
            AES32ESI:  begin w_f5_ok = 1'b1; w_op = AES_ESI;  end
            AES32ESMI: begin w_f5_ok = 1'b1; w_op = AES_ESMI; end
`ifdef CV32E40X_XIF_AES_DEC_EN
            AES32DSI:  begin w_f5_ok = 1'b1; w_op = AES_DSI;  end
            AES32DSMI: begin w_f5_ok = 1'b1; w_op = AES_DSMI; end
`endif
            default:   ;
        endcase
    end

    assign w_is_aes       = w_f5_ok && (issue_instr[6:0] == AES32) && (issue_instr[14:12] == 3'b000);
    assign w_unused_instr = ^issue_instr[24:15];

    assign w_tidx = r_tail[PW-1:0];
    assign w_hidx = r_head[PW-1:0];
    assign w_full = (r_head[PW] != r_tail[PW]) && (w_hidx == w_tidx);

    // Every handshake transfers on a cycle with valid & ready high; ready here is derived only
    // from registered pointers and the presented instruction, never from a same-cycle pop.
    assign issue_ready     = !w_full && !(issue_valid && w_is_aes && (issue_rs_valid != 2'b11));
    assign issue_accept    = issue_valid && issue_ready && w_is_aes;
    assign issue_writeback = issue_accept;

    assign w_res_free = !r_res_valid || result_ready;
    assign w_pop_kill = (r_state[w_hidx] == Q_KILLED);
    assign w_pop_exec = (r_state[w_hidx] == Q_COMMITTED) && w_res_free;

    cv32e40x_aes32_dp u_dp (
        .i_rs1 (r_rs1[w_hidx]),
        .i_rs2 (r_rs2[w_hidx]),
        .i_bs  (r_bs[w_hidx]),
        .i_op  (r_op[w_hidx]),
        .o_rd  (w_dp_rd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_res_valid <= 1'b0;
            r_res_id    <= '0;
            r_res_data  <= '0;
            r_res_rd    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_state[i] <= Q_FREE;
                r_id[i]    <= '0;
                r_op[i]    <= AES_ESI;
                r_bs[i]    <= '0;
                r_rd[i]    <= '0;
                r_rs1[i]   <= '0;
                r_rs2[i]   <= '0;
            end
        end else begin
            if (commit_valid) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (r_state[i] == Q_ISSUED && r_id[i] == commit_id) begin
                        r_state[i] <= commit_kill ? Q_KILLED : Q_COMMITTED;
                    end
                end
            end
            if (issue_accept) begin
                // A commit naming the ID being allocated this cycle lands on the new entry.
                if (commit_valid && commit_id == issue_id) begin
                    r_state[w_tidx] <= commit_kill ? Q_KILLED : Q_COMMITTED;
                end else begin
                    r_state[w_tidx] <= Q_ISSUED;
                end
                r_id[w_tidx]  <= issue_id;
                r_op[w_tidx]  <= w_op;
                r_bs[w_tidx]  <= issue_instr[31:30];
                r_rd[w_tidx]  <= issue_instr[11:7];
                r_rs1[w_tidx] <= issue_rs[0];
                r_rs2[w_tidx] <= issue_rs[1];
                r_tail        <= r_tail + 1'b1;
            end
            if (w_pop_kill || w_pop_exec) begin
                r_state[w_hidx] <= Q_FREE;
                r_head          <= r_head + 1'b1;
            end
            if (w_pop_exec) begin
                r_res_valid <= 1'b1;
                r_res_id    <= r_id[w_hidx];
                r_res_data  <= w_dp_rd;
                r_res_rd    <= r_rd[w_hidx];
            end else if (result_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign result_valid = r_res_valid;
    assign result_id    = r_res_id;
    assign result_data  = r_res_data;
    assign result_rd    = r_res_rd;
    assign result_we    = r_res_valid;

endmodule

// File: tb/tb_cv32e40x_xif_aes_queue.sv
// Directed bench for cv32e40x_xif_aes_queue with a result scoreboard; decrypt steps follow CV32E40X_XIF_AES_DEC_EN.
module tb_cv32e40x_xif_aes_queue;

    localparam int IDW = 4;
    localparam int W   = 42;

    localparam logic [4:0] F_ESI  = 5'b10001;
    localparam logic [4:0] F_ESMI = 5'b10011;
    localparam logic [4:0] F_DSI  = 5'b10101;
    localparam logic [4:0] F_DSMI = 5'b10111;

    logic              clk = 1'b0;
    logic              rst;
    logic              issue_valid;
    logic              issue_ready;
    logic [31:0]       issue_instr;
    logic [IDW-1:0]    issue_id;
    logic [1:0][31:0]  issue_rs;
    logic [1:0]        issue_rs_valid;
    logic              issue_accept;
    logic              issue_writeback;
    logic              commit_valid;
    logic [IDW-1:0]    commit_id;
    logic              commit_kill;
    logic              result_valid;
    logic              result_ready;
    logic [IDW-1:0]    result_id;
    logic [31:0]       result_data;
    logic [4:0]        result_rd;
    logic              result_we;

    logic [W-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    // ---------------- clock / reset / DUT ----------------
    always #5 clk = ~clk;

    cv32e40x_xif_aes_queue #(.X_ID_WIDTH(IDW), .X_RFR_WIDTH(32), .DEPTH(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .issue_valid     (issue_valid),
        .issue_ready     (issue_ready),
        .issue_instr     (issue_instr),
        .issue_id        (issue_id),
        .issue_rs        (issue_rs),
        .issue_rs_valid  (issue_rs_valid),
        .issue_accept    (issue_accept),
        .issue_writeback (issue_writeback),
        .commit_valid    (commit_valid),
        .commit_id       (commit_id),
        .commit_kill     (commit_kill),
        .result_valid    (result_valid),
        .result_ready    (result_ready),
        .result_id       (result_id),
        .result_data     (result_data),
        .result_rd       (result_rd),
        .result_we       (result_we)
    );

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach the summary");
        $fatal(1, "global timeout");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_instr(input logic [1:0] bs, input logic [4:0] f5, input logic [4:0] rd);
        return {bs, f5, 5'd2, 5'd1, 3'b000, rd, 7'b0110011};
    endfunction

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst && result_valid && result_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_result", {63'd0, result_valid}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("result", {22'd0, result_we, result_id, result_rd, result_data}, {22'd0, e});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [IDW-1:0] id, input logic [31:0] instr, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic cmt, input logic kill, input logic exp_acc,
                         input logic push, input logic [31:0] exp_data);
        logic done;
        done           = 1'b0;
        issue_valid    = 1'b1;
        issue_instr    = instr;
        issue_id       = id;
        issue_rs[0]    = rs1;
        issue_rs[1]    = rs2;
        issue_rs_valid = 2'b11;
        commit_valid   = cmt;
        commit_id      = id;
        commit_kill    = kill;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (issue_ready) begin
                check("issue_accept", {63'd0, issue_accept}, {63'd0, exp_acc});
                check("issue_writeback", {63'd0, issue_writeback}, {63'd0, exp_acc});
                if (push) exp_q.push_back({1'b1, id, instr[11:7], exp_data});
                done = 1'b1;
            end
            step();
        end
        issue_valid  = 1'b0;
        commit_valid = 1'b0;
        commit_kill  = 1'b0;
        check("issue_handshake", {63'd0, done}, 64'd1);
    endtask

    task automatic commit(input logic [IDW-1:0] id, input logic kill);
        commit_valid = 1'b1;
        commit_id    = id;
        commit_kill  = kill;
        step();
        commit_valid = 1'b0;
        commit_kill  = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        step();
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst            = 1'b1;
        issue_valid    = 1'b0;
        issue_instr    = '0;
        issue_id       = '0;
        issue_rs       = '0;
        issue_rs_valid = 2'b11;
        commit_valid   = 1'b0;
        commit_id      = '0;
        commit_kill    = 1'b0;
        result_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_issue_ready", {63'd0, issue_ready}, 64'd1);
        check("rst_issue_accept", {63'd0, issue_accept}, 64'd0);
        check("rst_result_valid", {63'd0, result_valid}, 64'd0);
        check("rst_result_data", {32'd0, result_data}, 64'd0);
        check("rst_result_id", {60'd0, result_id}, 64'd0);
        check("rst_result_rd", {59'd0, result_rd}, 64'd0);
        step();

        // esi zero operands, commit with issue: result two cycles after the handshake
        issue(4'd1, mk_instr(2'd0, F_ESI, 5'd10), 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00000063);
        @(negedge clk);
        check("latency_n1_valid", {63'd0, result_valid}, 64'd0);
        @(negedge clk);
        check("latency_n2_valid", {63'd0, result_valid}, 64'd1);
        check("latency_n2_data", {32'd0, result_data}, 64'h63);
        check("latency_n2_rd", {59'd0, result_rd}, 64'd10);
        step();
        wait_drain("drain_esi");

        // esmi and esi with several byte selects, issued back to back
        issue(4'd2, mk_instr(2'd0, F_ESMI, 5'd3), 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA56363C6);
        issue(4'd3, mk_instr(2'd1, F_ESMI, 5'd4), 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h6363C6A5);
        issue(4'd4, mk_instr(2'd2, F_ESMI, 5'd5), 32'h0, 32'h00010000, 1'b1, 1'b0, 1'b1, 1'b1, 32'h7CF8847C);
        issue(4'd5, mk_instr(2'd1, F_ESI, 5'd6), 32'h12345678, 32'h00005300, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1234BB78);
        issue(4'd6, mk_instr(2'd3, F_ESI, 5'd7), 32'hFFFFFFFF, 32'hFF000000, 1'b1, 1'b0, 1'b1, 1'b1, 32'hE9FFFFFF);
        wait_drain("drain_enc");

        // Non-AES instructions handshake without acceptance
        issue(4'd7, {7'b0, 5'd2, 5'd1, 3'b000, 5'd1, 7'b0110011}, 32'h1, 32'h2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        issue(4'd7, mk_instr(2'd0, F_ESI, 5'd1) | 32'h00001000, 32'h1, 32'h2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // AES instruction with missing operand holds ready low; non-AES does not
        issue_valid    = 1'b1;
        issue_instr    = mk_instr(2'd0, F_ESI, 5'd1);
        issue_id       = 4'd9;
        issue_rs_valid = 2'b01;
        @(negedge clk);
        check("rs_missing_ready", {63'd0, issue_ready}, 64'd0);
        check("rs_missing_accept", {63'd0, issue_accept}, 64'd0);
        step();
        issue_instr    = {7'b0, 5'd2, 5'd1, 3'b000, 5'd1, 7'b0110011};
        issue_rs_valid = 2'b00;
        @(negedge clk);
        check("nonaes_no_rs_ready", {63'd0, issue_ready}, 64'd1);
        step();
        issue_valid    = 1'b0;
        issue_rs_valid = 2'b11;

        // Decrypt variants
`ifdef CV32E40X_XIF_AES_DEC_EN
        issue(4'd8, mk_instr(2'd0, F_DSI, 5'd11), 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00000052);
        issue(4'd9, mk_instr(2'd0, F_DSMI, 5'd12), 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h50A7F451);
        issue(4'd10, mk_instr(2'd0, F_DSI, 5'd13), 32'hCAFEBABE, 32'h00000063, 1'b1, 1'b0, 1'b1, 1'b1, 32'hCAFEBABE);
`else
        issue(4'd8, mk_instr(2'd0, F_DSI, 5'd11), 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        issue(4'd9, mk_instr(2'd0, F_DSMI, 5'd12), 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
`endif
        wait_drain("drain_dec");

        // Fill the buffer, commit out of order, results stay in issue order
        issue(4'd1, mk_instr(2'd0, F_ESI, 5'd1), 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00000063);
        issue(4'd2, mk_instr(2'd0, F_ESI, 5'd2), 32'h0, 32'h00000001, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000007C);
        issue(4'd3, mk_instr(2'd0, F_ESI, 5'd3), 32'h0, 32'h000000FF, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00000016);
        issue(4'd4, mk_instr(2'd0, F_ESI, 5'd4), 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        issue_valid = 1'b1;
        issue_instr = mk_instr(2'd0, F_ESI, 5'd5);
        issue_id    = 4'd5;
        @(negedge clk);
        check("full_ready", {63'd0, issue_ready}, 64'd0);
        check("full_accept", {63'd0, issue_accept}, 64'd0);
        step();
        issue_valid = 1'b0;
        commit(4'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ooo_no_early_result", {63'd0, result_valid}, 64'd0);
        end
        step();
        commit(4'd1, 1'b0);
        @(negedge clk);
        check("full_pop_ready", {63'd0, issue_ready}, 64'd0);
        @(negedge clk);
        check("after_pop_ready", {63'd0, issue_ready}, 64'd1);
        step();
        commit(4'd3, 1'b0);
        commit(4'd4, 1'b1);
        wait_drain("drain_ooo");

        // Kill then commit, with result back-pressure
        result_ready = 1'b0;
        issue(4'd3, mk_instr(2'd0, F_ESMI, 5'd8), 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        issue(4'd4, mk_instr(2'd0, F_ESI, 5'd9), 32'h12345678, 32'h00000053, 1'b0, 1'b0, 1'b1, 1'b1, 32'h12345695);
        commit(4'd3, 1'b1);
        commit(4'd4, 1'b0);
        for (int i = 0; i < 10 && !result_valid; i++) @(negedge clk);
        check("hold_valid_seen", {63'd0, result_valid}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", {63'd0, result_valid}, 64'd1);
            check("hold_data", {32'd0, result_data}, 64'h12345695);
            check("hold_id", {60'd0, result_id}, 64'd4);
        end
        step();
        result_ready = 1'b1;
        wait_drain("drain_kill");
        @(negedge clk);
        check("kill_single_result", {63'd0, result_valid}, 64'd0);
        step();

        // Reset with a pending result and three entries in flight
        result_ready = 1'b0;
        issue(4'd8, mk_instr(2'd0, F_ESI, 5'd14), 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        issue(4'd5, mk_instr(2'd0, F_ESI, 5'd15), 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        issue(4'd6, mk_instr(2'd0, F_ESI, 5'd16), 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        issue(4'd7, mk_instr(2'd0, F_ESI, 5'd17), 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check("pending_before_rst", {63'd0, result_valid}, 64'd1);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("midrst_result_valid", {63'd0, result_valid}, 64'd0);
        check("midrst_issue_ready", {63'd0, issue_ready}, 64'd1);
        check("midrst_result_data", {32'd0, result_data}, 64'd0);
        step();
        rst          = 1'b0;
        result_ready = 1'b1;
        commit(4'd5, 1'b0);
        commit(4'd6, 1'b0);
        commit(4'd7, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_stale_result", {63'd0, result_valid}, 64'd0);
        end
        step();
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cv32e40x_xif_aes_queue.md
# cv32e40x_xif_aes_queue

Out-of-order-tolerant, multi-outstanding AES32 coprocessor on the CV32E40X eXtension interface (XIF).

- Accepts Zkne/Zknd `aes32*` instructions into a DEPTH-entry in-order buffer and tracks each entry's commit or kill by XIF ID.
- Executes committed entries through a single-cycle AES32 datapath.
- Returns results through a registered, back-pressured result port.
- Sits beside the core as an XIF coprocessor. It is the pipelined successor of the single-outstanding AES XIF unit.

## Interface
Parameters:
- X_ID_WIDTH, 4 — XIF instruction ID width
- X_RFR_WIDTH, 32 — operand/result width; only 32 supported
- DEPTH, 4 — outstanding instruction entries; power of two, ≥2

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- issue_valid  in  1  issue request valid
- issue_ready  out  1  issue handshake ready
- issue_instr  in  32  offloaded instruction
- issue_id  in  X_ID_WIDTH  instruction ID
- issue_rs  in  2×X_RFR_WIDTH  rs1 = [0], rs2 = [1]
- issue_rs_valid  in  2  operand valid flags
- issue_accept  out  1  instruction accepted
- issue_writeback  out  1  will write rd; equals issue_accept
- commit_valid  in  1  commit strobe
- commit_id  in  X_ID_WIDTH  committed/killed ID
- commit_kill  in  1  kill instead of commit
- result_valid  out  1  result valid
- result_ready  in  1  core accepts result
- result_id  out  X_ID_WIDTH  ID of result
- result_data  out  32  rd value
- result_rd  out  5  destination register (instr[11:7])
- result_we  out  1  constant 1 while result_valid

## Operation
**Decode**
- An instruction is AES when all of these hold:
  - opcode = 0110011
  - funct3 = 000
  - instr[29:25] ∈ {10001 esi, 10011 esmi, 10101 dsi, 10111 dsmi}
- bs = instr[31:30].

**Issue**
- issue_ready is low when the buffer is full, or when an AES instruction is presented with issue_rs_valid ≠ 2'b11.
- issue_ready is otherwise high, including for non-AES instructions.
- issue_accept = issue_valid & is_AES, qualified by the handshake.
- A non-AES handshake gives accept = 0, with no allocation.

**Buffer**
- Circular buffer with head/tail pointers of log2(DEPTH)+1 bits; the MSB distinguishes full from empty.
- Each entry stores: instr fields, id, rs1, rs2, and state.
- Entry states: FREE, ISSUED, COMMITTED, KILLED.

**Commit**
- commit_valid sets every non-FREE entry in ISSUED state whose id = commit_id to COMMITTED, or to KILLED when commit_kill = 1.
- Unmatched commits are ignored.
- A commit in the same cycle as the issue handshake of the same ID applies to the newly allocated entry.

**Head processing** (at most one head per cycle)
- Head KILLED: pop the entry, produce no result.
- Head COMMITTED and the result register is free or draining this cycle: compute through the datapath, load the result register, pop.
- Head ISSUED: stall.

**Result register**
- Holds data, id and rd, unchanged, until result_valid & result_ready.

**Datapath**
- x = rs2 byte bs.
- Non-mix operations: t = {24'b0, S(x)}, where S is the forward S-box (enc) or inverse S-box (dec).
- esmi: t = {3·S, S, S, 2·S}, listed [31:24]→[7:0], GF(2^8) with polynomial 0x11B.
- dsmi: t = {0B·S⁻¹, 0D·S⁻¹, 09·S⁻¹, 0E·S⁻¹}.
- rd = rs1 ^ rotl(t, 8·bs).

## Timing
**Reset**
- On rst: all entries FREE, pointers 0.
- issue_ready = 1, issue_accept = 0, result_valid = 0, result_data/id/rd = 0.
- Reset mid-operation drops all in-flight work; no result is emitted.

**Latency**
- Issue handshake in cycle N with commit by N → result_valid at N+2.
- Each cycle of commit delay adds one cycle.

**Throughput**
- One result per cycle while result_ready stays high.
- A killed head costs one cycle and produces no output.

**Full and stall**
- Full with simultaneous pop: issue_ready stays low that cycle; there is no combinational ready from pop.
- Results leave strictly in issue order.

## Configuration
- CV32E40X_XIF_AES_DEC_EN defined: dsi/dsmi are accepted, and the inverse S-box and inverse MixColumn are built.
- Undefined: dsi/dsmi decode as non-AES (accept = 0), and the decrypt logic is absent.

## Structure
**Package cv32e40x_pkg** holds:
- opcode constant AES32 = 7'b0110011
- funct5 constants AES32ESI/ESMI/DSI/DSMI
- aes_op_e enum
- entry state enum aes_q_state_e

**Sub-module cv32e40x_aes32_dp**
- Combinational rs1, rs2, bs, op → rd.
- Holds the S-boxes and the GF multiplies.

## Test plan
1. esi, rs1 = 0, rs2 = 0, bs = 0, committed in the same cycle → result_data = 0x00000063 two cycles after issue; result_rd = instr[11:7].
2. esmi, rs1 = 0, rs2 = 0, bs = 0 → 0xA56363C6. Repeat with bs = 1 and rs2 = 0 → 0x6363C6A5.
3. dsi, rs2 = 0, bs = 0 → 0x00000052 (macro defined). With the macro undefined → issue_accept = 0.
4. Issue IDs 1–4 (DEPTH = 4) without commit → 5th issue_ready = 0. Commit 2 before 1 → no result until 1 is committed, then results in order 1, 2.
5. Issue IDs 3, 4; kill 3, commit 4 → exactly one result, id = 4. Hold result_ready = 0 for 5 cycles → data stable, result_valid held.
6. Assert rst while 3 entries are in flight and a result is pending → next cycle result_valid = 0, issue_ready = 1, no stale result afterwards.
